dmem_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single port of the synchronous data memory / IO space between the CPU (master 0) and a debug/DMA host (master 1). Master 0 has fixed priority. A starvation counter forces a master-1 grant after a bounded wait. The block registers the memory command and routes the one-cycle-latency read data back to the master that issued the read.

---
 rtl/dmem_bus_arbiter_if.sv | 24 ++
 rtl/dmem_bus_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_bus_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_arbiter_if.sv
// Request/response port of one master on the shared data-memory bus.
// The master drives the command; the arbiter returns grant and read data.
interface dmem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Fixed-priority two-master arbiter for the data-memory port, with a bounded
// wait for master 1, a registered command stage and in-order read routing.
module dmem_bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_bus_arbiter_if.slave    m0,
  dmem_bus_arbiter_if.slave    m1,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 m1_starved
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_t;

  logic          force_m1, m0_gnt, m1_gnt, xfer, win_we;
  logic [CW-1:0] wait_cnt_d, wait_cnt_q;
  logic          starved_d, starved_q;
  logic          mem_en_d, mem_en_q, mem_we_d, mem_we_q;
  logic [AW-1:0] mem_addr_d, mem_addr_q;
  logic [DW-1:0] mem_wdata_d, mem_wdata_q;
  rsp_t          rsp1_d, rsp1_q, rsp2_d, rsp2_q;

  // Grant is combinational so a master sees it in the same cycle it requests.
  always_comb begin
    force_m1 = m1.req && (wait_cnt_q == LIMIT_C);
    m1_gnt   = m1.req && (force_m1 || !m0.req);
    m0_gnt   = m0.req && !force_m1;
    xfer     = m0_gnt || m1_gnt;
    win_we   = m1_gnt ? m1.we : m0.we;
  end

  // NOTE: every signal written in this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    mem_en_d    = xfer;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (!m1.req || m1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT_C) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
    starved_d = (wait_cnt_d == LIMIT_C);

    if (xfer) begin
      mem_we_d    = win_we;
      mem_addr_d  = m1_gnt ? m1.addr  : m0.addr;
      mem_wdata_d = m1_gnt ? m1.wdata : m0.wdata;
    end

    rsp1_d.valid = xfer && !win_we;
    rsp1_d.owner = m1_gnt;
    rsp2_d       = rsp1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      starved_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp1_q      <= '0;
      rsp2_q      <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      starved_q   <= starved_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp1_q      <= rsp1_d;
      rsp2_q      <= rsp2_d;
    end
  end

  assign m0.gnt     = m0_gnt;
  assign m1.gnt     = m1_gnt;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign m1_starved = starved_q;

  // Responses return in issue order; the owner bit steers the single rdata stream.
  assign m0.rvalid = rsp2_q.valid && !rsp2_q.owner;
  assign m1.rvalid = rsp2_q.valid &&  rsp2_q.owner;
  assign m0.rdata  = mem_rdata;
  assign m1.rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: a per-cycle vector table followed by
// hand-written contention, withdrawal and mid-stream reset sequences.
module tb_dmem_bus_arbiter;

  localparam logic [31:0] DATA_A = 32'hAAAA_0020;
  localparam logic [31:0] DATA_B = 32'hBBBB_0024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we, m1_starved;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_model [0:63];

  int checks = 0;
  int errors = 0;

  dmem_bus_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
  dmem_bus_arbiter_if #(.AW(32), .DW(32)) m1_bus ();

  dmem_bus_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_bus.slave),
    .m1         (m1_bus.slave),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .m1_starved (m1_starved)
  );

  always #5 clk = ~clk;

  // Synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr[7:2]];
    end
  end

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic        e_m0_gnt, e_m1_gnt, e_en, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_rv0, e_rv1;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(
    logic m0r, logic m0w, logic [31:0] m0a, logic [31:0] m0d,
    logic m1r, logic m1w, logic [31:0] m1a, logic [31:0] m1d,
    logic g0, logic g1, logic en, logic we, logic [31:0] a, logic [31:0] d,
    logic rv0, logic rv1, logic [31:0] rd);
    vec_t v;
    v.m0_req = m0r; v.m0_we = m0w; v.m0_addr = m0a; v.m0_wdata = m0d;
    v.m1_req = m1r; v.m1_we = m1w; v.m1_addr = m1a; v.m1_wdata = m1d;
    v.e_m0_gnt = g0; v.e_m1_gnt = g1; v.e_en = en; v.e_we = we;
    v.e_addr = a; v.e_wdata = d; v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_rdata = rd;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic m0r, logic m0w, logic [31:0] m0a, logic [31:0] m0d,
                       logic m1r, logic m1w, logic [31:0] m1a, logic [31:0] m1d);
    m0_bus.req = m0r; m0_bus.we = m0w; m0_bus.addr = m0a; m0_bus.wdata = m0d;
    m1_bus.req = m1r; m1_bus.we = m1w; m1_bus.addr = m1a; m1_bus.wdata = m1d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, " mem_en"},    {31'd0, mem_en},        32'd0);
    check({tag, " mem_we"},    {31'd0, mem_we},        32'd0);
    check({tag, " mem_addr"},  mem_addr,               32'd0);
    check({tag, " mem_wdata"}, mem_wdata,              32'd0);
    check({tag, " m0_rvalid"}, {31'd0, m0_bus.rvalid}, 32'd0);
    check({tag, " m1_rvalid"}, {31'd0, m1_bus.rvalid}, 32'd0);
    check({tag, " starved"},   {31'd0, m1_starved},    32'd0);
    check({tag, " gnt"},       {30'd0, m1_bus.gnt, m0_bus.gnt}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = '0;
    mem_model[32'h20 >> 2] = DATA_A;
    mem_model[32'h24 >> 2] = DATA_B;

    // Single-master traffic, interleaved reads and an m1 write burst.
    vecs.push_back(mk(1,1,'h10,'h11, 0,0,0,0,       1,0, 0,0,'h00,'h00, 0,0,0));
    vecs.push_back(mk(1,0,'h10,0,    0,0,0,0,       1,0, 1,1,'h10,'h11, 0,0,0));
    vecs.push_back(mk(1,0,'h20,0,    0,0,0,0,       1,0, 1,0,'h10,'h00, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       1,0,'h24,0,    0,1, 1,0,'h20,'h00, 1,0,'h11));
    vecs.push_back(mk(0,0,0,0,       1,1,'h40,'hA1, 0,1, 1,0,'h24,'h00, 1,0,DATA_A));
    vecs.push_back(mk(0,0,0,0,       1,1,'h44,'hA2, 0,1, 1,1,'h40,'hA1, 0,1,DATA_B));
    vecs.push_back(mk(0,0,0,0,       1,1,'h48,'hA3, 0,1, 1,1,'h44,'hA2, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,       0,0, 1,1,'h48,'hA3, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,       0,0, 0,0,'h48,'hA3, 0,0,0));
    vecs.push_back(mk(1,0,'h40,0,    0,0,0,0,       1,0, 0,0,'h48,'hA3, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,       0,0, 1,0,'h40,'h00, 0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,       0,0, 0,0,'h40,'h00, 1,0,'hA1));

    drive(0,0,0,0, 0,0,0,0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].m0_req, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_wdata,
            vecs[i].m1_req, vecs[i].m1_we, vecs[i].m1_addr, vecs[i].m1_wdata);
      @(negedge clk);
      check($sformatf("v%0d m0_gnt", i), {31'd0, m0_bus.gnt}, {31'd0, vecs[i].e_m0_gnt});
      check($sformatf("v%0d m1_gnt", i), {31'd0, m1_bus.gnt}, {31'd0, vecs[i].e_m1_gnt});
      check($sformatf("v%0d mem_en", i), {31'd0, mem_en},     {31'd0, vecs[i].e_en});
      check($sformatf("v%0d mem_we", i), {31'd0, mem_we},     {31'd0, vecs[i].e_we});
      check($sformatf("v%0d mem_addr", i),  mem_addr,  vecs[i].e_addr);
      check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d m0_rvalid", i), {31'd0, m0_bus.rvalid}, {31'd0, vecs[i].e_rv0});
      check($sformatf("v%0d m1_rvalid", i), {31'd0, m1_bus.rvalid}, {31'd0, vecs[i].e_rv1});
      check($sformatf("v%0d starved", i),   {31'd0, m1_starved},    32'd0);
      if (vecs[i].e_rv0) check($sformatf("v%0d m0_rdata", i), m0_bus.rdata, vecs[i].e_rdata);
      if (vecs[i].e_rv1) check($sformatf("v%0d m1_rdata", i), m1_bus.rdata, vecs[i].e_rdata);
      next_cycle();
    end

    // Contention: both masters hold req; four m0 grants then one forced m1 grant.
    drive(1,0,'h30,0, 1,0,'h34,0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("cont%0d m0_gnt", i),  {31'd0, m0_bus.gnt}, (i % 5 == 4) ? 32'd0 : 32'd1);
      check($sformatf("cont%0d m1_gnt", i),  {31'd0, m1_bus.gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("cont%0d starved", i), {31'd0, m1_starved}, (i % 5 == 4) ? 32'd1 : 32'd0);
      next_cycle();
    end
    drive(0,0,0,0, 0,0,0,0);
    repeat (3) next_cycle();

    // Withdrawal: two blocked cycles, one cycle dropped, then a full fresh wait.
    drive(1,1,'h50,'h5, 1,1,'h54,'h6);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("wd_pre%0d m1_gnt", i), {31'd0, m1_bus.gnt}, 32'd0);
      next_cycle();
    end
    m1_bus.req = 1'b0;
    next_cycle();
    m1_bus.req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("wd%0d m0_gnt", i),  {31'd0, m0_bus.gnt}, (i == 4) ? 32'd0 : 32'd1);
      check($sformatf("wd%0d m1_gnt", i),  {31'd0, m1_bus.gnt}, (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("wd%0d starved", i), {31'd0, m1_starved}, (i == 4) ? 32'd1 : 32'd0);
      next_cycle();
    end
    drive(0,0,0,0, 0,0,0,0);
    repeat (3) next_cycle();

    // Reset with two reads in flight: nothing may come back afterwards.
    drive(1,0,'h20,0, 0,0,0,0);
    next_cycle();
    drive(0,0,0,0, 1,0,'h24,0);
    next_cycle();
    drive(0,0,0,0, 0,0,0,0);
    rst = 1'b1;
    #2;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("post_rst%0d m0_rvalid", i), {31'd0, m0_bus.rvalid}, 32'd0);
      check($sformatf("post_rst%0d m1_rvalid", i), {31'd0, m1_bus.rvalid}, 32'd0);
      check($sformatf("post_rst%0d mem_en", i),    {31'd0, mem_en},        32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
